hist_stat: RTL and testbench

- Per-frame 256-bin luminance histogram accumulator for the hist_enhance pipeline.
- Counts 8-bit pixels into an internal 256 x BITWIDTH RAM during the frame.
- Signals end-of-frame on video_eop, then serves the CDF stage's sequential bin reads over the load interface.
- A clean pulse from the CDF stage zeroes all bins, ready for the next frame.

---
 rtl/hist_stat_if.sv | 25 ++
 rtl/hist_stat.sv | 91 +++++++++
 tb/tb_hist_stat.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/hist_stat_if.sv
// Pixel stream, frame/clean control and bin-read bus of the hist_stat accumulator.
interface hist_stat_if #(
  parameter int BITWIDTH = 21
);
  logic                pix_valid;
  logic [7:0]          pix_data;
  logic                pix_eop;
  logic                video_eop;
  logic                load;
  logic [7:0]          load_addr;
  logic [BITWIDTH-1:0] load_data;
  logic                clean;
  logic                busy;
  logic                drop_err;

  modport master (
    output pix_valid, pix_data, pix_eop, load, load_addr, clean,
    input  video_eop, load_data, busy, drop_err
  );

  modport slave (
    input  pix_valid, pix_data, pix_eop, load, load_addr, clean,
    output video_eop, load_data, busy, drop_err
  );
endinterface

// File: rtl/hist_stat.sv
// 256-bin luminance histogram: clear sweep, accumulate with write forwarding, drain, hold for reads.
// HIST_SAT_EN: when defined, bins saturate at all-ones instead of wrapping.
module hist_stat #(
  parameter int BITWIDTH    = 21,
  parameter bit SWEEP_START = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  hist_stat_if.slave  bus
);

  typedef enum logic [1:0] {CLEAR, ACCUM, DRAIN, HOLD} state_t;

  state_t              state, state_nxt;
  logic [BITWIDTH-1:0] mem [256];
  logic [BITWIDTH-1:0] q;
  logic [7:0]          raddr, waddr, clr_addr, s1_addr, w_addr;
  logic [BITWIDTH-1:0] wdata, w_data, operand, incr;
  logic                wen, accept, ld_vld, dcnt, drop_err;
  // [0]: pixel read issued last cycle (write this cycle); [1]: write committed last edge
  logic [1:0]          vld_pipe;

  assign accept = (state == ACCUM) && bus.pix_valid && !bus.clean;

  // Load owns the read port; pixels and loads are not expected together in ACCUM
  assign raddr = bus.load ? bus.load_addr : bus.pix_data;

  assign wen   = (state == CLEAR) || vld_pipe[0];
  assign waddr = (state == CLEAR) ? clr_addr : s1_addr;
  assign wdata = (state == CLEAR) ? '0 : incr;

  // RAM returns old data on a same-edge collision, so bypass the write just committed
  assign operand = (vld_pipe[1] && (w_addr == s1_addr)) ? w_data : q;

`ifdef HIST_SAT_EN
  assign incr = (&operand) ? operand : operand + BITWIDTH'(1);
`else
  assign incr = operand + BITWIDTH'(1);
`endif

  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
    q <= mem[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SWEEP_START ? CLEAR : ACCUM;
      vld_pipe <= '0;
      s1_addr  <= '0;
      w_addr   <= '0;
      w_data   <= '0;
      clr_addr <= '0;
      ld_vld   <= 1'b0;
      dcnt     <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      vld_pipe <= {vld_pipe[0], accept};
      s1_addr  <= bus.pix_data;
      w_addr   <= s1_addr;
      w_data   <= incr;
      ld_vld   <= bus.load;
      dcnt     <= (state == DRAIN) && !dcnt;
      if (bus.clean)          clr_addr <= '0;
      else if (state == CLEAR) clr_addr <= clr_addr + 8'd1;
      if (bus.clean)                                 drop_err <= 1'b0;
      else if (bus.pix_valid && (state != ACCUM))    drop_err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.clean) begin
      state_nxt = CLEAR;
    end else begin
      case (state)
        CLEAR:   if (clr_addr == 8'hff) state_nxt = ACCUM;
        ACCUM:   if (bus.pix_valid && bus.pix_eop) state_nxt = DRAIN;
        DRAIN:   if (dcnt) state_nxt = HOLD;
        default: state_nxt = state;
      endcase
    end
  end

  assign bus.video_eop = (state == DRAIN) && dcnt;
  assign bus.busy      = (state == CLEAR) || (state == DRAIN);
  assign bus.drop_err  = drop_err;
  assign bus.load_data = ld_vld ? q : '1;

endmodule

// File: tb/tb_hist_stat.sv
// Directed bench for hist_stat: sweep, forwarding, load timing, drop/clean, abort, overflow.
module tb_hist_stat;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hist_stat_if #(.BITWIDTH(21)) bus ();
  hist_stat_if #(.BITWIDTH(4))  bus4 ();

  hist_stat #(.BITWIDTH(21), .SWEEP_START(1'b1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  hist_stat #(.BITWIDTH(4),  .SWEEP_START(1'b1)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  int checks = 0;
  int errors = 0;
  localparam logic [20:0] ONES = 21'h1fffff;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 400) begin tick(); n++; end
  endtask

  task automatic read_bin(input logic [7:0] a, output logic [20:0] v);
    bus.load = 1'b1; bus.load_addr = a;
    tick();
    bus.load = 1'b0;
    v = bus.load_data;
  endtask

  task automatic check_all_zero(input string name);
    int bad = 0;
    for (int i = 0; i < 256; i++) begin
      bus.load = 1'b1; bus.load_addr = 8'(i);
      tick();
      checks++;
      if (bus.load_data !== 21'd0) begin
        errors++; bad++;
        if (bad < 4) $display("FAIL %s bin %0d got %0d exp 0", name, i, bus.load_data);
      end
    end
    bus.load = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    int n;
    tick();
    checks++; if (bus.busy !== 1'b1)      begin errors++; $display("FAIL rst_busy got %b exp 1", bus.busy); end
    checks++; if (bus.load_data !== ONES) begin errors++; $display("FAIL rst_load_data got %h exp %h", bus.load_data, ONES); end
    checks++; if (bus.video_eop !== 1'b0) begin errors++; $display("FAIL rst_video_eop got %b exp 0", bus.video_eop); end
    checks++; if (bus.drop_err !== 1'b0)  begin errors++; $display("FAIL rst_drop_err got %b exp 0", bus.drop_err); end
    rst_n = 1'b1;
    wait_idle(n);
    checks++; if (n != 256) begin errors++; $display("FAIL sweep_len got %0d exp 256", n); end
    repeat (4) tick();
    check_all_zero("reset_sweep");
  endtask

  task automatic test_forward;
    logic [7:0] px [5] = '{8'd5, 8'd5, 8'd5, 8'd7, 8'd5};
    logic [20:0] v;
    for (int i = 0; i < 5; i++) begin
      bus.pix_valid = 1'b1; bus.pix_data = px[i]; bus.pix_eop = (i == 4);
      tick();
    end
    bus.pix_valid = 1'b0; bus.pix_eop = 1'b0;
    checks++; if (bus.video_eop !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL eop_t1 got eop=%b busy=%b exp 0/1", bus.video_eop, bus.busy); end
    tick();
    checks++; if (bus.video_eop !== 1'b1) begin errors++; $display("FAIL eop_t2 got %b exp 1", bus.video_eop); end
    tick();
    checks++; if (bus.video_eop !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL eop_t3 got eop=%b busy=%b exp 0/0", bus.video_eop, bus.busy); end
    read_bin(8'd5, v);
    checks++; if (v !== 21'd4) begin errors++; $display("FAIL fwd_bin5 got %0d exp 4", v); end
    read_bin(8'd7, v);
    checks++; if (v !== 21'd1) begin errors++; $display("FAIL fwd_bin7 got %0d exp 1", v); end
  endtask

  task automatic test_load_timing;
    logic [20:0] e;
    tick();
    checks++; if (bus.load_data !== ONES) begin errors++; $display("FAIL ld_pre got %h exp %h", bus.load_data, ONES); end
    for (int i = 0; i < 256; i++) begin
      bus.load = 1'b1; bus.load_addr = 8'(i);
      tick();
      e = (i == 5) ? 21'd4 : (i == 7) ? 21'd1 : 21'd0;
      checks++;
      if (bus.load_data !== e) begin errors++; $display("FAIL ld_burst bin %0d got %0d exp %0d", i, bus.load_data, e); end
    end
    bus.load = 1'b0;
    tick();
    checks++; if (bus.load_data !== ONES) begin errors++; $display("FAIL ld_post got %h exp %h", bus.load_data, ONES); end
  endtask

  task automatic test_drop_clean;
    int n;
    bus.pix_valid = 1'b1; bus.pix_data = 8'd9;
    tick();
    bus.pix_valid = 1'b0;
    checks++; if (bus.drop_err !== 1'b1) begin errors++; $display("FAIL drop_hold got %b exp 1", bus.drop_err); end
    bus.clean = 1'b1;
    tick();
    bus.clean = 1'b0;
    checks++; if (bus.drop_err !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL drop_clean got err=%b busy=%b exp 0/1", bus.drop_err, bus.busy); end
    bus.pix_valid = 1'b1; bus.pix_data = 8'd5;
    tick();
    bus.pix_valid = 1'b0;
    checks++; if (bus.drop_err !== 1'b1) begin errors++; $display("FAIL drop_clear got %b exp 1", bus.drop_err); end
    wait_idle(n);
    checks++; if (n != 255) begin errors++; $display("FAIL drop_sweep_len got %0d exp 255", n); end
    check_all_zero("drop_clean");
  endtask

  task automatic test_abort;
    int n;
    logic [20:0] v;
    bus.pix_valid = 1'b1; bus.pix_data = 8'd3;
    tick(); tick();
    bus.pix_eop = 1'b1; bus.clean = 1'b1;
    tick();
    bus.pix_valid = 1'b0; bus.pix_eop = 1'b0; bus.clean = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.video_eop !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL abort_t%0d got eop=%b busy=%b exp 0/1", i, bus.video_eop, bus.busy); end
      tick();
    end
    wait_idle(n);
    checks++; if (n != 253) begin errors++; $display("FAIL abort_sweep_len got %0d exp 253", n); end
    read_bin(8'd3, v);
    checks++; if (v !== 21'd0) begin errors++; $display("FAIL abort_bin3 got %0d exp 0", v); end
  endtask

  task automatic test_overflow;
    logic [3:0] exp9;
`ifdef HIST_SAT_EN
    exp9 = 4'd15;
`else
    exp9 = 4'd1;
`endif
    for (int i = 0; i < 17; i++) begin
      bus4.pix_valid = 1'b1; bus4.pix_data = 8'd9; bus4.pix_eop = (i == 16);
      tick();
    end
    bus4.pix_valid = 1'b0; bus4.pix_eop = 1'b0;
    tick(); tick();
    checks++; if (bus4.busy !== 1'b0) begin errors++; $display("FAIL ovf_hold got busy=%b exp 0", bus4.busy); end
    bus4.load = 1'b1; bus4.load_addr = 8'd9;
    tick();
    checks++; if (bus4.load_data !== exp9) begin errors++; $display("FAIL ovf_bin9 got %0d exp %0d", bus4.load_data, exp9); end
    bus4.load_addr = 8'd8;
    tick();
    bus4.load = 1'b0;
    checks++; if (bus4.load_data !== 4'd0) begin errors++; $display("FAIL ovf_bin8 got %0d exp 0", bus4.load_data); end
    tick();
    checks++; if (bus4.load_data !== 4'hf) begin errors++; $display("FAIL ovf_idle got %h exp f", bus4.load_data); end
  endtask

  initial begin
    bus.pix_valid = 1'b0; bus.pix_data = '0; bus.pix_eop = 1'b0;
    bus.load = 1'b0; bus.load_addr = '0; bus.clean = 1'b0;
    bus4.pix_valid = 1'b0; bus4.pix_data = '0; bus4.pix_eop = 1'b0;
    bus4.load = 1'b0; bus4.load_addr = '0; bus4.clean = 1'b0;
    test_reset();
    test_forward();
    test_load_timing();
    test_drop_clean();
    test_abort();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
